// File: rtl/tick_sched_pkg.sv
// Shared constants and config-FSM encoding for the tick scheduler.
package tick_sched_pkg;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_PERIOD_W = 16;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} cfg_state_e;
endpackage

// File: rtl/tick_scheduler_channel.sv
// Channel file revision constant; per-channel logic is implemented in tick_channel.sv.
package tick_scheduler_channel_pkg;
  localparam int CHANNEL_FILE_REV = 1;
endpackage

// File: rtl/tick_channel.sv
// One pulse channel: period register, tick counter, active flag and registered wrap pulse.
module tick_channel #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                apply,
  input  logic [PERIOD_W-1:0] new_period,
  input  logic                new_en,
  output logic                wrap,
  output logic                pulse,
  output logic                active
);
  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic                active_q, active_d, pulse_q, pulse_d;

  always_comb begin
    wrap     = tick && active_q && (cnt_q == period_q - ONE);
    cnt_d    = cnt_q;
    period_d = period_q;
    active_d = active_q;
    pulse_d  = wrap;
    if (apply) begin
      // a wrap coinciding with apply still pulses under the old period
      cnt_d    = '0;
      period_d = new_period;
      active_d = new_en && (new_period != '0);
    end else if (tick && active_q) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      period_q <= '0;
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      active_q <= active_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse  = pulse_q;
  assign active = active_q;
endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick divider with a single-slot config path applied glitch-free on channel wrap.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick_in,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [PERIOD_W-1:0]       cfg_period,
  input  logic                      cfg_en,
  output logic                      cfg_applied,
  output logic [NUM_CH-1:0]         ch_pulse,
  output logic [NUM_CH-1:0]         ch_active
);
  localparam int CH_W = $clog2(NUM_CH);

  cfg_state_e          state_q, state_d;
  logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
  logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
  logic                pend_en_q, pend_en_d;
  logic                applied_q, applied_d;
  logic                arm_q, arm_d;
  logic                apply_now, tick_g;
  logic [NUM_CH-1:0]   wrap, apply_vec;

  // inputs are masked on the first edge out of reset
  assign tick_g = tick_in && arm_q;

  always_comb begin
    state_d       = state_q;
    pend_ch_d     = pend_ch_q;
    pend_period_d = pend_period_q;
    pend_en_d     = pend_en_q;
    applied_d     = 1'b0;
    apply_now     = 1'b0;
    arm_d         = 1'b1;
    case (state_q)
      IDLE: if (cfg_valid && arm_q) begin
        state_d       = PEND;
        pend_ch_d     = cfg_ch;
        pend_period_d = cfg_period;
        pend_en_d     = cfg_en;
      end
      PEND: if (!ch_active[pend_ch_q] || !pend_en_q || (pend_period_q == '0) ||
                wrap[pend_ch_q]) begin
        apply_now = 1'b1;
        applied_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pend_ch_q     <= '0;
      pend_period_q <= '0;
      pend_en_q     <= 1'b0;
      applied_q     <= 1'b0;
      arm_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_ch_q     <= pend_ch_d;
      pend_period_q <= pend_period_d;
      pend_en_q     <= pend_en_d;
      applied_q     <= applied_d;
      arm_q         <= arm_d;
    end
  end

  assign cfg_ready   = (state_q == IDLE);
  assign cfg_applied = applied_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    assign apply_vec[i] = apply_now && (pend_ch_q == CH_W'(i));

    tick_channel #(.PERIOD_W(PERIOD_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick_g),
      .apply      (apply_vec[i]),
      .new_period (pend_period_q),
      .new_en     (pend_en_q),
      .wrap       (wrap[i]),
      .pulse      (ch_pulse[i]),
      .active     (ch_active[i])
    );
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios plus random traffic against a cycle model.
module tb_tick_scheduler;
  localparam int NCH = 4;
  localparam int PW  = 16;

  logic          clk = 1'b0, rst_n = 1'b0, tick_in = 1'b0, cfg_valid = 1'b0, cfg_en = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [PW-1:0] cfg_period = '0;
  logic          cfg_ready, cfg_applied;
  logic [NCH-1:0] ch_pulse, ch_active;

  int n_tests = 0, n_fail = 0;
  int n_app = 0, ch2_pulses = 0;

  // model state
  int   m_cnt[NCH], m_per[NCH];
  bit   m_act[NCH];
  logic [NCH-1:0] m_pulse;
  bit   m_pend, m_pen, m_applied, m_armed;
  int   m_pch, m_pper;

  always #5 clk = ~clk;

  tick_scheduler #(.NUM_CH(NCH), .PERIOD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_en(cfg_en), .cfg_applied(cfg_applied),
    .ch_pulse(ch_pulse), .ch_active(ch_active)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] m_act_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_per[i] = 0; m_act[i] = 0; end
    m_pulse = '0; m_pend = 0; m_pen = 0; m_applied = 0; m_armed = 0; m_pch = 0; m_pper = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at that edge.
  task automatic m_step();
    bit tk, vld, ap, was_pend;
    bit wr[NCH];
    tk  = tick_in && m_armed;
    vld = cfg_valid && m_armed;
    for (int i = 0; i < NCH; i++)
      wr[i] = tk && m_act[i] && (m_per[i] > 0) && (m_cnt[i] == m_per[i] - 1);
    ap = m_pend && (!m_act[m_pch] || !m_pen || m_pper == 0 || wr[m_pch]);
    for (int i = 0; i < NCH; i++) begin
      m_pulse[i] = wr[i];
      if (ap && i == m_pch) begin
        m_cnt[i] = 0; m_per[i] = m_pper; m_act[i] = m_pen && (m_pper != 0);
      end else if (tk && m_act[i]) begin
        m_cnt[i] = wr[i] ? 0 : m_cnt[i] + 1;
      end
    end
    m_applied = ap;
    was_pend  = m_pend;
    if (ap) m_pend = 0;
    if (!was_pend && vld) begin
      m_pend = 1; m_pch = int'(cfg_ch); m_pper = int'(cfg_period); m_pen = cfg_en;
    end
    m_armed = 1;
  endtask

  task automatic clk1();
    @(posedge clk);
    if (rst_n) m_step(); else m_reset();
    #1;
  endtask

  // continuous comparison against the model
  always @(negedge clk) begin
    chk("ch_pulse", 32'(ch_pulse), 32'(m_pulse));
    chk("ch_active", 32'(ch_active), 32'(m_act_vec()));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    chk("cfg_applied", 32'(cfg_applied), 32'(m_applied));
    if (cfg_applied) n_app++;
    if (ch_pulse[2]) ch2_pulses++;
  end

  initial begin
    int k, c3, cb, snap;
    m_reset();
    clk1(); clk1();
    chk("rst_pulse", 32'(ch_pulse), 0);
    chk("rst_active", 32'(ch_active), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_applied", 32'(cfg_applied), 0);

    // S1: first edge after release ignores inputs; ch0 period 3, tick every 4 clk
    rst_n = 1; cfg_valid = 1; cfg_ch = 0; cfg_period = 3; cfg_en = 1; tick_in = 1;
    clk1();
    chk("s1_first_edge_ignored", 32'(cfg_ready), 1);
    tick_in = 0;
    clk1();
    chk("s1_accept", 32'(cfg_ready), 0);
    cfg_valid = 0;
    clk1();
    chk("s1_applied_next", 32'(cfg_applied), 1);
    chk("s1_ch0_active", 32'(ch_active[0]), 1);
    for (int t = 1; t <= 9; t++) begin
      tick_in = 1; clk1(); tick_in = 0;
      chk("s1_pulse_every_3rd", 32'(ch_pulse[0]), (t % 3 == 0) ? 1 : 0);
      clk1(); clk1(); clk1();
    end

    // S2: ch1 period 5, reconfigure to 2 mid-count
    cfg_valid = 1; cfg_ch = 1; cfg_period = 5; cfg_en = 1;
    clk1(); cfg_valid = 0; clk1();
    chk("s2_ch1_applied", 32'(ch_active[1]), 1);
    for (int t = 0; t < 2; t++) begin tick_in = 1; clk1(); tick_in = 0; clk1(); end
    cfg_valid = 1; cfg_period = 2;
    clk1(); cfg_valid = 0;
    chk("s2_accept", 32'(cfg_ready), 0);
    k = 0;
    while (k < 10) begin
      tick_in = 1; clk1(); tick_in = 0; k++;
      if (cfg_applied) begin
        chk("s2_old_period_pulse", 32'(ch_pulse[1]), 1);
        break;
      end
      chk("s2_ready_low_until_wrap", 32'(cfg_ready), 0);
      clk1();
    end
    chk("s2_ticks_to_apply", k, 3);
    clk1();
    c3 = 0;
    for (int t = 1; t <= 6; t++) begin
      tick_in = 1; clk1(); tick_in = 0;
      chk("s2_new_period_pulse", 32'(ch_pulse[1]), (t % 2 == 0) ? 1 : 0);
      c3 += int'(ch_pulse[1]);
      clk1();
    end
    chk("s2_pulse_count", c3, 3);

    // S3: period 0 disables; held request waits for IDLE
    cfg_valid = 1; cfg_ch = 2; cfg_period = 0; cfg_en = 1;
    clk1();
    chk("s3_accept", 32'(cfg_ready), 0);
    cfg_ch = 3; cfg_period = 2;
    clk1();
    chk("s3_applied", 32'(cfg_applied), 1);
    chk("s3_ch2_inactive", 32'(ch_active[2]), 0);
    clk1();
    chk("s3_second_accept", 32'(cfg_ready), 0);
    cfg_valid = 0;
    clk1();
    chk("s3_ch3_active", 32'(ch_active[3]), 1);

    // S4: ch0 period 1 with ch3 period 2, continuous ticks
    cfg_valid = 1; cfg_ch = 0; cfg_period = 1; cfg_en = 1;
    clk1(); cfg_valid = 0; tick_in = 1;
    k = 0;
    while (k < 10) begin clk1(); k++; if (cfg_applied) break; end
    chk("s4_apply_bounded", 32'(k < 10), 1);
    c3 = 0; cb = 0;
    for (int t = 0; t < 8; t++) begin
      clk1();
      chk("s4_ch0_every_tick", 32'(ch_pulse[0]), 1);
      c3 += int'(ch_pulse[3]);
      cb += int'(ch_pulse[0] & ch_pulse[3]);
    end
    tick_in = 0;
    chk("s4_ch3_count", c3, 4);
    chk("s4_together", cb, 4);
    clk1();
    chk("s4_ch2_never_pulsed", ch2_pulses, 0);

    // S5: asynchronous reset while a config is pending
    cfg_valid = 1; cfg_ch = 1; cfg_period = 7; cfg_en = 1;
    clk1(); cfg_valid = 0; clk1();
    chk("s5_pending", 32'(cfg_ready), 0);
    #2 rst_n = 0; m_reset();
    #1;
    chk("s5_async_active", 32'(ch_active), 0);
    chk("s5_async_pulse", 32'(ch_pulse), 0);
    chk("s5_async_ready", 32'(cfg_ready), 1);
    chk("s5_async_applied", 32'(cfg_applied), 0);
    clk1(); clk1();
    rst_n = 1; tick_in = 1;
    snap = n_app;
    for (int t = 0; t < 20; t++) clk1();
    @(negedge clk); #1;
    chk("s5_no_applied_after", n_app - snap, 0);
    chk("s5_still_inactive", 32'(ch_active), 0);

    // S6: random traffic, occasional resets
    for (int t = 0; t < 3000; t++) begin
      tick_in    = 1'($urandom_range(0, 1));
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_period = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom_range(1, 6));
      cfg_en     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0; m_reset(); clk1(); rst_n = 1;
      end
      clk1();
    end
    tick_in = 0; cfg_valid = 0;
    clk1(); @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
